// File: rtl/fp_pkg.sv
// Shared definitions for the FP add/sub controller and its datapath.
package fp_pkg;

    localparam int unsigned EXP_W_DEF = 8;
    localparam int unsigned MAN_W_DEF = 23;

    // Operation encoding shared with the datapath adder
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ALIGN = 3'd1,
        ST_ADD   = 3'd2,
        ST_NORM  = 3'd3,
        ST_ROUND = 3'd4,
        ST_CHECK = 3'd5,
        ST_FIX   = 3'd6,
        ST_DONE  = 3'd7
    } state_t;

    // Registered single-bit control outputs toward datapath and issue stage
    typedef struct packed {
        logic busy;
        logic done;
        logic sel_round;
        logic shift_en;
        logic shift_dir;   // 0 left, 1 right
        logic exp_en;
        logic exp_inc;     // 1 increment, 0 decrement
        logic align_en;
        logic add_en;
        logic round_en;
        logic norm_err;
    } ctrl_t;

endpackage

// File: rtl/fp_shift_amt.sv
// Signed exponent difference to saturated alignment shift magnitude.
module fp_shift_amt #(
    parameter int unsigned EXP_W     = 8,
    parameter int unsigned SAT_SHIFT = 26
) (
    input  logic [EXP_W:0]   diff,
    output logic [EXP_W-1:0] amt_c
);

    localparam int unsigned DW = EXP_W + 1;

    logic [EXP_W:0] mag;

    // Magnitude kept at EXP_W+1 bits so the most negative diff stays positive
    always_comb begin
        mag = diff[EXP_W] ? (~diff + DW'(1)) : diff;
        if (mag > DW'(SAT_SHIFT)) begin
            amt_c = EXP_W'(SAT_SHIFT);
        end else begin
            amt_c = mag[EXP_W-1:0];
        end
    end

endmodule

// File: rtl/fp_addsub_ctrl.sv
// Multicycle control FSM sequencing align/add/normalise/round/fix for FP add/sub.
module fp_addsub_ctrl
    import fp_pkg::*;
#(
    parameter int unsigned EXP_W     = EXP_W_DEF,
    parameter int unsigned MAN_W     = MAN_W_DEF,
    parameter int unsigned SAT_SHIFT = MAN_W + 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [EXP_W:0]   exp_diff,
    input  logic             sum_ovf,
    input  logic             sum_msb,
    input  logic             sum_zero,
    input  logic             round_ovf,
    output logic             busy,
    output logic             done,
    output logic             op_q,
    output logic [EXP_W-1:0] shift_right,
    output logic             sel_small_a,
    output logic             sel_big_b,
    output logic             sel_round,
    output logic             shift_en,
    output logic             shift_left_or_right,
    output logic             exp_en,
    output logic             inc_or_dec,
    output logic             align_en,
    output logic             add_en,
    output logic             round_en,
    output logic             norm_err
);

    localparam int unsigned CNT_W   = $clog2(MAN_W + 2);
    localparam int unsigned CNT_MAX = MAN_W + 1;

    state_t           state_q, state_d;
    ctrl_t            ctrl_q, ctrl_d;
    logic             op_d;
    logic [EXP_W:0]   diff_q, diff_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic [EXP_W-1:0] shr_q, shr_d;
    logic             ssa_q, ssa_d;
    logic             sbb_q, sbb_d;
    logic [EXP_W-1:0] amt_c;
    logic             accept_c;

    fp_shift_amt #(
        .EXP_W    (EXP_W),
        .SAT_SHIFT(SAT_SHIFT)
    ) u_shift_amt (
        .diff (diff_q),
        .amt_c(amt_c)
    );

    // State, latches and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            ctrl_q  <= '0;
            op_q    <= 1'b0;
            diff_q  <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            shr_q   <= '0;
            ssa_q   <= 1'b0;
            sbb_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
            op_q    <= op_d;
            diff_q  <= diff_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            shr_q   <= shr_d;
            ssa_q   <= ssa_d;
            sbb_q   <= sbb_d;
        end
    end

    // Next-state and output decode; the done cycle still reports busy so a start there is dropped
    always_comb begin
        state_d  = state_q;
        ctrl_d   = '0;
        op_d     = op_q;
        diff_d   = diff_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        shr_d    = shr_q;
        ssa_d    = ssa_q;
        sbb_d    = sbb_q;
        accept_c = (state_q == ST_IDLE) && start && !ctrl_q.busy;

        case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    op_d    = op;
                    diff_d  = exp_diff;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    state_d = ST_ALIGN;
                end
            end
            ST_ALIGN: begin
                ctrl_d.align_en = 1'b1;
                ssa_d   = diff_q[EXP_W];
                sbb_d   = ~diff_q[EXP_W];
                shr_d   = amt_c;
                state_d = ST_ADD;
            end
            ST_ADD: begin
                ctrl_d.add_en = 1'b1;
                state_d = ST_NORM;
            end
            ST_NORM: begin
                if (sum_zero) begin
                    state_d = ST_DONE;
                end else if (sum_ovf) begin
                    ctrl_d.shift_en  = 1'b1;
                    ctrl_d.shift_dir = 1'b1;
                    ctrl_d.exp_en    = 1'b1;
                    ctrl_d.exp_inc   = 1'b1;
                    state_d = ST_ROUND;
                end else if (!sum_msb) begin
                    if (cnt_q < CNT_W'(CNT_MAX)) begin
                        ctrl_d.shift_en = 1'b1;
                        ctrl_d.exp_en   = 1'b1;
                        cnt_d = cnt_q + CNT_W'(1);
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end
                end else begin
                    state_d = ST_ROUND;
                end
            end
            ST_ROUND: begin
                ctrl_d.round_en = 1'b1;
                state_d = ST_CHECK;
            end
            ST_CHECK: begin
                ctrl_d.sel_round = 1'b1;
                state_d = round_ovf ? ST_FIX : ST_DONE;
            end
            ST_FIX: begin
                ctrl_d.sel_round = 1'b1;
                ctrl_d.shift_en  = 1'b1;
                ctrl_d.shift_dir = 1'b1;
                ctrl_d.exp_en    = 1'b1;
                ctrl_d.exp_inc   = 1'b1;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                ctrl_d.done     = 1'b1;
                ctrl_d.norm_err = err_q;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        ctrl_d.busy = accept_c || (state_q != ST_IDLE);
    end

    assign busy                = ctrl_q.busy;
    assign done                = ctrl_q.done;
    assign shift_right         = shr_q;
    assign sel_small_a         = ssa_q;
    assign sel_big_b           = sbb_q;
    assign sel_round           = ctrl_q.sel_round;
    assign shift_en            = ctrl_q.shift_en;
    assign shift_left_or_right = ctrl_q.shift_dir;
    assign exp_en              = ctrl_q.exp_en;
    assign inc_or_dec          = ctrl_q.exp_inc;
    assign align_en            = ctrl_q.align_en;
    assign add_en              = ctrl_q.add_en;
    assign round_en            = ctrl_q.round_en;
    assign norm_err            = ctrl_q.norm_err;

endmodule

// File: tb/tb_fp_addsub_ctrl.sv
// Scoreboard bench for fp_addsub_ctrl: randomized transactions against a behavioural model.
module tb_fp_addsub_ctrl;

    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam int SAT   = MAN_W + 3;

    // Scenario kinds seen by the normaliser
    localparam int K_ZERO = 0;
    localparam int K_OVF  = 1;
    localparam int K_LEFT = 2;
    localparam int K_ERR  = 3;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic             op;
    logic [EXP_W:0]   exp_diff;
    logic             sum_ovf, sum_msb, sum_zero, round_ovf;
    logic             busy, done, op_q;
    logic [EXP_W-1:0] shift_right;
    logic             sel_small_a, sel_big_b, sel_round, shift_en, shift_left_or_right;
    logic             exp_en, inc_or_dec, align_en, add_en, round_en, norm_err;

    fp_addsub_ctrl #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .exp_diff(exp_diff),
        .sum_ovf(sum_ovf), .sum_msb(sum_msb), .sum_zero(sum_zero), .round_ovf(round_ovf),
        .busy(busy), .done(done), .op_q(op_q), .shift_right(shift_right),
        .sel_small_a(sel_small_a), .sel_big_b(sel_big_b), .sel_round(sel_round),
        .shift_en(shift_en), .shift_left_or_right(shift_left_or_right),
        .exp_en(exp_en), .inc_or_dec(inc_or_dec), .align_en(align_en),
        .add_en(add_en), .round_en(round_en), .norm_err(norm_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic op;
        int   shr;
        logic small_a;
        int   lat;
        int   left;
        int   right;
        int   rnd;
        int   selr;
        logic err;
        int   issue;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Monitor: accumulates strobes between done pulses and compares at each done
    int   n_left, n_right, n_inc, n_dec, n_align, n_add, n_rnd, n_selr;
    exp_t me;

    always @(negedge clk) begin
        if (reset) begin
            n_left = 0; n_right = 0; n_inc = 0; n_dec = 0;
            n_align = 0; n_add = 0; n_rnd = 0; n_selr = 0;
        end else begin
            if (shift_en && !shift_left_or_right) n_left++;
            if (shift_en && shift_left_or_right)  n_right++;
            if (exp_en && inc_or_dec)             n_inc++;
            if (exp_en && !inc_or_dec)            n_dec++;
            if (align_en)  n_align++;
            if (add_en)    n_add++;
            if (round_en)  n_rnd++;
            if (sel_round) n_selr++;
            if (done) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    me = exp_q.pop_front();
                    chk("latency",     cyc - me.issue - 1, me.lat);
                    chk("op_q",        int'(op_q), int'(me.op));
                    chk("shift_right", int'(shift_right), me.shr);
                    chk("sel_small_a", int'(sel_small_a), int'(me.small_a));
                    chk("sel_big_b",   int'(sel_big_b), int'(!me.small_a));
                    chk("left_shifts", n_left, me.left);
                    chk("right_shifts", n_right, me.right);
                    chk("exp_dec",     n_dec, me.left);
                    chk("exp_inc",     n_inc, me.right);
                    chk("align_en",    n_align, 1);
                    chk("add_en",      n_add, 1);
                    chk("round_en",    n_rnd, me.rnd);
                    chk("sel_round",   n_selr, me.selr);
                    chk("norm_err",    int'(norm_err), int'(me.err));
                    chk("busy_at_done", int'(busy), 1);
                end
                n_left = 0; n_right = 0; n_inc = 0; n_dec = 0;
                n_align = 0; n_add = 0; n_rnd = 0; n_selr = 0;
            end
        end
    end

    task automatic chk_all_zero(input string tag);
        int v;
        v = int'(busy) + int'(done) + int'(op_q) + int'(shift_right) + int'(sel_small_a)
          + int'(sel_big_b) + int'(sel_round) + int'(shift_en) + int'(shift_left_or_right)
          + int'(exp_en) + int'(inc_or_dec) + int'(align_en) + int'(add_en)
          + int'(round_en) + int'(norm_err);
        chk({tag, "_outputs_zero"}, v, 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_shift_right"}, int'(shift_right), 0);
    endtask

    // Behavioural expectation from scenario parameters; called at a negedge with DUT idle
    task automatic run_txn(input int kind, input int k, input bit ro,
                           input logic op_i, input logic [EXP_W:0] diff_i,
                           input bit noise, input bit track);
        exp_t e;
        int   d, lc;
        bit   seen;
        d = diff_i[EXP_W] ? int'(diff_i) - (1 << (EXP_W + 1)) : int'(diff_i);
        e.op      = op_i;
        e.small_a = (d < 0);
        e.shr     = (d < 0) ? -d : d;
        if (e.shr > SAT) e.shr = SAT;
        e.err = 1'b0;
        case (kind)
            K_ZERO:  begin e.lat = 4; e.left = 0; e.right = 0; e.rnd = 0; e.selr = 0; end
            K_OVF:   begin e.lat = 6 + int'(ro); e.left = 0; e.right = 1 + int'(ro);
                           e.rnd = 1; e.selr = 1 + int'(ro); end
            K_LEFT:  begin e.lat = 6 + k + int'(ro); e.left = k; e.right = int'(ro);
                           e.rnd = 1; e.selr = 1 + int'(ro); end
            default: begin e.lat = 4 + MAN_W + 1; e.left = MAN_W + 1; e.right = 0;
                           e.rnd = 0; e.selr = 0; e.err = 1'b1; end
        endcase
        e.issue = cyc;
        if (track) exp_q.push_back(e);

        start     = 1'b1;
        op        = op_i;
        exp_diff  = diff_i;
        sum_zero  = (kind == K_ZERO);
        sum_ovf   = (kind == K_OVF);
        round_ovf = ro;
        sum_msb   = (kind == K_LEFT) ? (k == 0) : (kind == K_OVF);
        lc = 0;
        seen = 0;
        if (!track) return;
        for (int n = 0; n < 60 && !seen; n++) begin
            @(negedge clk);
            if (noise && ($urandom_range(0, 2) == 0)) begin
                start    = 1'b1;
                op       = 1'($urandom);
                exp_diff = (EXP_W + 1)'($urandom);
            end else begin
                start = 1'b0;
            end
            if (shift_en && !shift_left_or_right) lc++;
            if (kind == K_LEFT) sum_msb = (lc >= k);
            if (done) begin
                seen = 1;
                start    = noise ? 1'b1 : 1'b0;
                op       = 1'($urandom);
                exp_diff = (EXP_W + 1)'($urandom);
                @(negedge clk);
                start = 1'b0;
                chk("start_in_done_ignored", int'(busy), 0);
            end
        end
        if (!seen) chk("done_timeout", 0, 1);
    endtask

    initial begin
        int kind, k;
        bit ro;
        reset = 1'b1; start = 1'b0; op = 1'b0; exp_diff = '0;
        sum_ovf = 1'b0; sum_msb = 1'b0; sum_zero = 1'b0; round_ovf = 1'b0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        reset = 1'b0;
        @(negedge clk);

        run_txn(K_LEFT, 0, 1'b0, 1'b0, 9'd3,   1'b0, 1'b1);
        run_txn(K_LEFT, 0, 1'b0, 1'b1, 9'h1D8, 1'b0, 1'b1);
        run_txn(K_LEFT, 4, 1'b0, 1'b0, 9'd0,   1'b0, 1'b1);
        run_txn(K_OVF,  0, 1'b1, 1'b1, 9'd5,   1'b0, 1'b1);
        run_txn(K_ZERO, 0, 1'b0, 1'b0, 9'd9,   1'b0, 1'b1);
        run_txn(K_ERR,  0, 1'b0, 1'b1, 9'h100, 1'b0, 1'b1);
        run_txn(K_LEFT, 1, 1'b1, 1'b0, 9'd255, 1'b1, 1'b1);
        run_txn(K_LEFT, 2, 1'b0, 1'b1, 9'd26,  1'b1, 1'b1);
        run_txn(K_LEFT, 0, 1'b0, 1'b0, 9'h1E6, 1'b1, 1'b1);

        for (int t = 0; t < 30; t++) begin
            kind = $urandom_range(0, 9);
            kind = (kind < 1) ? K_ZERO : (kind < 3) ? K_OVF : (kind < 9) ? K_LEFT : K_ERR;
            k    = $urandom_range(0, 6);
            ro   = 1'($urandom);
            run_txn(kind, k, ro, 1'($urandom), (EXP_W + 1)'($urandom), 1'($urandom), 1'b1);
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end

        // Abort in NORM: reset clears everything and no done follows
        run_txn(K_LEFT, 5, 1'b0, 1'b1, 9'd77, 1'b0, 1'b0);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort_left_shifting", int'(shift_en), 1);
        reset = 1'b1;
        @(negedge clk);
        chk_all_zero("abort");
        reset = 1'b0;
        begin
            int dn = 0;
            repeat (12) begin
                @(negedge clk);
                if (done) dn++;
            end
            chk("abort_no_done", dn, 0);
        end

        run_txn(K_LEFT, 3, 1'b1, 1'b1, 9'h1F0, 1'b1, 1'b1);
        repeat (4) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
